// File: rtl/rsp_manager_if.sv
// Response-frame handshake plus the toggle-per-byte link to the byte transmitter.
interface rsp_manager_if #(parameter int FRAME_BYTES = 4);
  logic [FRAME_BYTES*8-1:0] rsp_frame;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [7:0]               out_byte;
  logic                     byte_avail;
  logic                     byte_sent;

  // Response logic and transmitter side
  modport master (
    output rsp_frame, rsp_valid, byte_sent,
    input  rsp_ready, out_byte, byte_avail
  );

  // Frame serializer side
  modport slave (
    input  rsp_frame, rsp_valid, byte_sent,
    output rsp_ready, out_byte, byte_avail
  );
endinterface

// File: rtl/rsp_manager.sv
// rsp_manager: accepts a whole response frame and hands it to the byte
// transmitter MSB byte first, one byte per byte_sent toggle.
module rsp_manager #(
  parameter int FRAME_BYTES = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_en,
  input  logic          i_abort,
  rsp_manager_if.slave  bus,
  output logic          o_busy,
  output logic          o_frame_done
);

  localparam int W  = FRAME_BYTES * 8;
  localparam int RW = $clog2(FRAME_BYTES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [RW-1:0] LAST_IDX = RW'(FRAME_BYTES - 1);
  localparam logic [RW-1:0] ONE      = RW'(1);

  logic [0:0]    r_state,      w_state_nxt;
  logic [W-1:0]  r_sr,         w_sr_nxt;
  logic [RW-1:0] r_remaining,  w_remaining_nxt;
  logic [7:0]    r_out_byte,   w_out_byte_nxt;
  logic          r_byte_avail, w_byte_avail_nxt;
  logic          r_frame_done, w_frame_done_nxt;
  logic          r_sent_seen,  w_sent_seen_nxt;
  logic          r_synced;
  logic          w_ready;
  logic          w_accept;
  logic          w_ack;

  assign w_ready  = i_reset_n & i_en & (r_state == IDLE);
  assign w_accept = w_ready & bus.rsp_valid;
  // Toggles are meaningless until sent_seen has been resynchronised after reset.
  assign w_ack    = r_synced & (bus.byte_sent ^ r_sent_seen);

  // While enabled the last-seen level always follows byte_sent (an ack is
  // consumed, an idle toggle is discarded); while disabled a pending ack is
  // held, except that the first edge after reset always resynchronises.
  assign w_sent_seen_nxt = (i_en | ~r_synced) ? bus.byte_sent : r_sent_seen;

  // Next-state logic: abort beats accept and ack; en low freezes everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_sr_nxt         = r_sr;
    w_remaining_nxt  = r_remaining;
    w_out_byte_nxt   = r_out_byte;
    w_byte_avail_nxt = r_byte_avail;
    w_frame_done_nxt = 1'b0;
    if (i_en) begin
      if (i_abort) begin
        w_state_nxt     = IDLE;
        w_remaining_nxt = {RW{1'b0}};
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              w_out_byte_nxt   = bus.rsp_frame[W-1 -: 8];
              w_byte_avail_nxt = ~r_byte_avail;
              w_sr_nxt         = bus.rsp_frame << 4'd8;
              w_remaining_nxt  = LAST_IDX;
              w_state_nxt      = SEND;
            end else begin
              w_state_nxt = IDLE;
            end
          end
          SEND: begin
            if (w_ack) begin
              if (r_remaining != {RW{1'b0}}) begin
                w_out_byte_nxt   = r_sr[W-1 -: 8];
                w_byte_avail_nxt = ~r_byte_avail;
                w_sr_nxt         = r_sr << 4'd8;
                w_remaining_nxt  = r_remaining - ONE;
              end else begin
                w_frame_done_nxt = 1'b1;
                w_state_nxt      = IDLE;
              end
            end else begin
              w_state_nxt = SEND;
            end
          end
          default: begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = {RW{1'b0}};
          end
        endcase
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_sr         <= {W{1'b0}};
      r_remaining  <= {RW{1'b0}};
      r_out_byte   <= 8'h00;
      r_byte_avail <= 1'b0;
      r_frame_done <= 1'b0;
      r_sent_seen  <= 1'b0;
      r_synced     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sr         <= w_sr_nxt;
      r_remaining  <= w_remaining_nxt;
      r_out_byte   <= w_out_byte_nxt;
      r_byte_avail <= w_byte_avail_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sent_seen  <= w_sent_seen_nxt;
      r_synced     <= 1'b1;
    end
  end

  assign bus.rsp_ready  = w_ready;
  assign bus.out_byte   = r_out_byte;
  assign bus.byte_avail = r_byte_avail;
  assign o_busy         = (r_state == SEND);
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_rsp_manager.sv
// Self-checking bench for rsp_manager: directed scenarios plus a randomized
// run, all compared against a byte-queue reference model.
module tb_rsp_manager;
  localparam int FB = 4;
  localparam int W  = FB * 8;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic abort;
  logic busy;
  logic frame_done;

  rsp_manager_if #(.FRAME_BYTES(FB)) bus();

  rsp_manager #(.FRAME_BYTES(FB)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_en         (en),
    .i_abort      (abort),
    .bus          (bus),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a frame becomes a queue of bytes; each acknowledgement
  // pops the next one, and an ack with an empty queue ends the frame.
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  logic       m_avail, m_busy, m_done, m_seen, m_synced;
  int         m_accepts = 0;
  int         m_frames  = 0;

  function automatic void model_reset();
    m_q.delete();
    m_byte = 8'h00; m_avail = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_seen = 1'b0; m_synced = 1'b0;
  endfunction

  function automatic logic m_ready();
    return reset_n & en & ~m_busy;
  endfunction

  function automatic void model_edge();
    logic ack;
    ack = m_synced && (bus.byte_sent != m_seen);
    m_done = 1'b0;
    if (en) begin
      if (abort) begin
        m_busy = 1'b0;
        m_q.delete();
      end else if (!m_busy) begin
        if (bus.rsp_valid) begin
          for (int k = FB - 1; k >= 0; k--) m_q.push_back(bus.rsp_frame[k*8 +: 8]);
          m_byte = m_q.pop_front();
          m_avail = ~m_avail;
          m_busy = 1'b1;
          m_accepts++;
        end
      end else if (ack) begin
        if (m_q.size() != 0) begin
          m_byte = m_q.pop_front();
          m_avail = ~m_avail;
        end else begin
          m_done = 1'b1;
          m_busy = 1'b0;
          m_frames++;
        end
      end
      m_seen = bus.byte_sent;
    end
    if (!m_synced) begin
      m_seen = bus.byte_sent;
      m_synced = 1'b1;
    end
  endfunction

  // Advance the model and the DUT by one clock; sample 1 ns after the edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; abort = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_frame = {W{1'b0}}; bus.byte_sent = 1'b1;
    model_reset();
    #12;
    n_checks++;
    if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_hold got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, 12'h000);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {m_byte, m_avail, m_busy, m_done, m_ready()}) begin
        n_errors++;
        $display("FAIL reset_model got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {m_byte, m_avail, m_busy, m_done, m_ready()});
      end
    end
    n_checks++;
    if ({bus.out_byte, bus.byte_avail, bus.rsp_ready} !== {8'h00, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_idle got %h exp %h", {bus.out_byte, bus.byte_avail, bus.rsp_ready}, {8'h00, 1'b0, 1'b1});
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_b [4];
    logic prev;
    int toggles;
    exp_b = '{8'hAD, 8'hBE, 8'hEF, 8'hEF};
    prev = bus.byte_avail;
    toggles = 0;
    bus.rsp_frame = 32'hDEADBEEF; bus.rsp_valid = 1'b1;
    cycle();
    if (bus.byte_avail !== prev) toggles++;
    prev = bus.byte_avail;
    n_checks++;
    if ({bus.out_byte, busy, bus.rsp_ready} !== {8'hDE, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL single_accept got %h exp %h", {bus.out_byte, busy, bus.rsp_ready}, {8'hDE, 1'b1, 1'b0});
    end
    bus.rsp_valid = 1'b0; bus.rsp_frame = $urandom;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j == 2) bus.byte_sent = ~bus.byte_sent;
        cycle();
        if (bus.byte_avail !== prev) toggles++;
        prev = bus.byte_avail;
        n_checks++;
        if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {m_byte, m_avail, m_busy, m_done, m_ready()}) begin
          n_errors++;
          $display("FAIL single_model got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {m_byte, m_avail, m_busy, m_done, m_ready()});
        end
      end
      n_checks++;
      if ({bus.out_byte, frame_done} !== {exp_b[i], (i == 3) ? 1'b1 : 1'b0}) begin
        n_errors++;
        $display("FAIL single_byte%0d got %h exp %h", i, {bus.out_byte, frame_done}, {exp_b[i], (i == 3) ? 1'b1 : 1'b0});
      end
    end
    cycle();
    n_checks++;
    if ({frame_done, bus.rsp_ready, toggles} !== {1'b0, 1'b1, 32'd4}) begin
      n_errors++;
      $display("FAIL single_end done=%b ready=%b toggles=%0d exp 0 1 4", frame_done, bus.rsp_ready, toggles);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    logic [7:0] exp_b [8];
    logic prev;
    int acc0, fr0, cyc;
    bit chk_next, seen_done;
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    acc0 = m_accepts; fr0 = m_frames; cyc = 0;
    chk_next = 1'b0; seen_done = 1'b0;
    prev = bus.byte_avail;
    bus.rsp_frame = 32'h01020304; bus.rsp_valid = 1'b1;
    while (m_frames < fr0 + 2 && cyc < 80) begin
      if (cyc % 2 == 1) bus.byte_sent = ~bus.byte_sent;
      cycle();
      cyc++;
      n_checks++;
      if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {m_byte, m_avail, m_busy, m_done, m_ready()}) begin
        n_errors++;
        $display("FAIL b2b_model got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {m_byte, m_avail, m_busy, m_done, m_ready()});
      end
      if (bus.byte_avail !== prev) got.push_back(bus.out_byte);
      prev = bus.byte_avail;
      if (chk_next) begin
        chk_next = 1'b0;
        n_checks++;
        if ({busy, bus.out_byte} !== {1'b1, 8'hA0}) begin
          n_errors++;
          $display("FAIL b2b_reaccept got %h exp %h", {busy, bus.out_byte}, {1'b1, 8'hA0});
        end
      end
      if (frame_done === 1'b1 && !seen_done) begin
        seen_done = 1'b1;
        chk_next = 1'b1;
      end
      if (m_accepts == acc0 + 1) bus.rsp_frame = 32'hA0B0C0D0;
      if (m_accepts >= acc0 + 2) bus.rsp_valid = 1'b0;
    end
    bus.rsp_valid = 1'b0;
    n_checks++;
    if (m_frames < fr0 + 2 || got.size() != 8) begin
      n_errors++;
      $display("FAIL b2b_count got %0d bytes exp 8 (cycles %0d)", got.size(), cyc);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL b2b_byte%0d got %h exp %h", i, got[i], exp_b[i]);
      end
    end
    cycle();
  endtask

  task automatic test_enable_gating();
    logic [W-1:0] fr;
    fr = $urandom;
    bus.rsp_frame = fr; bus.rsp_valid = 1'b1;
    cycle();
    bus.rsp_valid = 1'b0;
    cycle();
    bus.byte_sent = ~bus.byte_sent;
    cycle();
    n_checks++;
    if (bus.out_byte !== fr[23:16]) begin
      n_errors++;
      $display("FAIL en_byte2 got %h exp %h", bus.out_byte, fr[23:16]);
    end
    en = 1'b0;
    bus.byte_sent = ~bus.byte_sent;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {fr[23:16], m_avail, 1'b1, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL en_frozen got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {fr[23:16], m_avail, 1'b1, 1'b0, 1'b0});
      end
    end
    en = 1'b1;
    cycle();
    n_checks++;
    if ({bus.out_byte, bus.byte_avail, busy} !== {fr[15:8], m_avail, 1'b1}) begin
      n_errors++;
      $display("FAIL en_byte3 got %h exp %h", {bus.out_byte, bus.byte_avail, busy}, {fr[15:8], m_avail, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) bus.byte_sent = ~bus.byte_sent;
      cycle();
      n_checks++;
      if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {m_byte, m_avail, m_busy, m_done, m_ready()}) begin
        n_errors++;
        $display("FAIL en_model got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {m_byte, m_avail, m_busy, m_done, m_ready()});
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] got[$];
    logic [7:0] exp_b [4];
    logic prev;
    int dones;
    exp_b = '{8'h55, 8'h66, 8'h77, 8'h88};
    bus.rsp_frame = 32'h11223344; bus.rsp_valid = 1'b1;
    cycle();
    bus.rsp_valid = 1'b0;
    prev = bus.byte_avail;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    n_checks++;
    if ({busy, bus.rsp_ready, bus.out_byte, bus.byte_avail, frame_done} !== {1'b0, 1'b1, 8'h11, prev, 1'b0}) begin
      n_errors++;
      $display("FAIL abort_state got %h exp %h", {busy, bus.rsp_ready, bus.out_byte, bus.byte_avail, frame_done}, {1'b0, 1'b1, 8'h11, prev, 1'b0});
    end
    bus.byte_sent = ~bus.byte_sent;
    cycle();
    cycle();
    n_checks++;
    if ({busy, frame_done, bus.out_byte} !== {1'b0, 1'b0, 8'h11}) begin
      n_errors++;
      $display("FAIL abort_quiet got %h exp %h", {busy, frame_done, bus.out_byte}, {1'b0, 1'b0, 8'h11});
    end
    dones = 0;
    bus.rsp_frame = 32'h55667788; bus.rsp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0 && i % 3 == 0) bus.byte_sent = ~bus.byte_sent;
      cycle();
      bus.rsp_valid = 1'b0;
      n_checks++;
      if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {m_byte, m_avail, m_busy, m_done, m_ready()}) begin
        n_errors++;
        $display("FAIL abort_model got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {m_byte, m_avail, m_busy, m_done, m_ready()});
      end
      if (bus.byte_avail !== prev) got.push_back(bus.out_byte);
      prev = bus.byte_avail;
      if (frame_done === 1'b1) dones++;
    end
    n_checks++;
    if (got.size() != 4 || dones != 1) begin
      n_errors++;
      $display("FAIL abort_next bytes=%0d dones=%0d exp 4 1", got.size(), dones);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL abort_byte%0d got %h exp %h", i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.rsp_frame = $urandom; bus.rsp_valid = 1'b1;
    cycle();
    bus.rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.byte_sent = ~bus.byte_sent;
      cycle();
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mreset_pre busy got %b exp 1", busy);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== 12'h000) begin
      n_errors++;
      $display("FAIL mreset_async got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, 12'h000);
    end
    bus.byte_sent = ~bus.byte_sent;
    @(negedge clk);
    reset_n = 1'b1;
    bus.byte_sent = ~bus.byte_sent;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        n_errors++;
        $display("FAIL mreset_stale got %h exp %h", {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      abort = ($urandom_range(0, 39) == 0);
      bus.rsp_valid = $urandom_range(0, 1);
      bus.rsp_frame = $urandom;
      if ($urandom_range(0, 2) == 0) bus.byte_sent = ~bus.byte_sent;
      cycle();
      n_checks++;
      if ({bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready} !== {m_byte, m_avail, m_busy, m_done, m_ready()}) begin
        n_errors++;
        $display("FAIL random_model cyc=%0d got %h exp %h", i, {bus.out_byte, bus.byte_avail, busy, frame_done, bus.rsp_ready}, {m_byte, m_avail, m_busy, m_done, m_ready()});
      end
    end
    en = 1'b1; abort = 1'b0; bus.rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable_gating();
    test_abort();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
